// File: rtl/v_pkg.sv
`default_nettype none
// ============================================================================
// Module   : v_pkg
// Brief    : Shared op codes, FSM state type and decode helpers for the VLSU.
// Revision : 1.0
// ============================================================================
package v_pkg;

    localparam int VLEN = 128;

    localparam logic [3:0] VLSU_VLE8   = 4'h0;
    localparam logic [3:0] VLSU_VLE16  = 4'h1;
    localparam logic [3:0] VLSU_VLE32  = 4'h2;
    localparam logic [3:0] VLSU_VLSE8  = 4'h4;
    localparam logic [3:0] VLSU_VLSE16 = 4'h5;
    localparam logic [3:0] VLSU_VLSE32 = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // log2(SEW/8); unknown ops fall back to 32-bit elements
    function automatic logic [1:0] sew_log2(input logic [3:0] op);
        case (op)
            VLSU_VLE8,  VLSU_VLSE8:  sew_log2 = 2'd0;
            VLSU_VLE16, VLSU_VLSE16: sew_log2 = 2'd1;
            default:                 sew_log2 = 2'd2;
        endcase
    endfunction

    function automatic logic is_strided(input logic [3:0] op);
        is_strided = (op == VLSU_VLSE8) || (op == VLSU_VLSE16) || (op == VLSU_VLSE32);
    endfunction

    // log2 of the register-group size
    function automatic logic [1:0] lmul_log2(input logic [2:0] lmul);
        case (lmul)
            3'b001:  lmul_log2 = 2'd1;
            3'b010:  lmul_log2 = 2'd2;
            default: lmul_log2 = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/v_lsu_addrgen.sv
`default_nettype none
// ============================================================================
// Module   : v_lsu_addrgen
// Brief    : Combinational per-lane element address generator for one beat.
// Revision : 1.0
// ============================================================================
module v_lsu_addrgen (
    input  logic [31:0] base,
    input  logic [31:0] stride,
    input  logic [3:0]  op,
    input  logic [3:0]  beat,
    output logic [31:0] mem_addr0,
    output logic [31:0] mem_addr1,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_addr3
);
    import v_pkg::*;

    logic [31:0] w_addr [4];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            logic [31:0] w_idx;
            assign w_idx     = {26'd0, beat, 2'(k)};
            // Both forms wrap modulo 2^32; the product keeps only its low word
            assign w_addr[k] = is_strided(op) ? base + w_idx * stride
                                              : base + (w_idx << sew_log2(op));
        end
    endgenerate

    assign mem_addr0 = w_addr[0];
    assign mem_addr1 = w_addr[1];
    assign mem_addr2 = w_addr[2];
    assign mem_addr3 = w_addr[3];

endmodule
`default_nettype wire

// File: rtl/v_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : v_load_sequencer
// Brief    : Multi-beat vector load controller packing lane data into a group image.
// Revision : 1.0
// ============================================================================
module v_load_sequencer #(
    parameter int VLEN  = v_pkg::VLEN,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              vlsu_op,
    input  logic [2:0]              lmul,
    input  logic [31:0]             base_addr,
    input  logic [31:0]             stride,
    output logic                    busy,
    output logic                    mem_req,
    output logic [31:0]             mem_addr0,
    output logic [31:0]             mem_addr1,
    output logic [31:0]             mem_addr2,
    output logic [31:0]             mem_addr3,
    input  logic                    mem_valid,
    input  logic [31:0]             l_data_in0,
    input  logic [31:0]             l_data_in1,
    input  logic [31:0]             l_data_in2,
    input  logic [31:0]             l_data_in3,
    output logic [VLEN*LANES-1:0]   l_data_out,
    output logic                    l_done
);
    import v_pkg::*;

    localparam int IMG_W = VLEN * LANES;
    localparam int OFF_W = $clog2(IMG_W);

    lsu_state_t         r_state, w_state_nxt;
    logic [3:0]         r_op;
    logic [2:0]         r_lmul;
    logic [31:0]        r_base;
    logic [31:0]        r_stride;
    logic [3:0]         r_beat;
    logic [IMG_W-1:0]   r_img, w_img;

    logic [1:0]         w_sew;
    logic [4:0]         w_total;
    logic               w_last;
    logic               w_accept;
    logic               w_capture;
    logic [OFF_W-1:0]   w_off;
    logic [31:0]        w_lane [LANES];
    logic [31:0]        w_ga0, w_ga1, w_ga2, w_ga3;

    assign w_lane[0] = l_data_in0;
    assign w_lane[1] = l_data_in1;
    assign w_lane[2] = l_data_in2;
    assign w_lane[3] = l_data_in3;

    // total_beats = (VLEN/(SEW*4)) * num_reg, all powers of two
    assign w_sew     = sew_log2(r_op);
    assign w_total   = 5'd1 << ((3'd2 + {1'b0, lmul_log2(r_lmul)}) - {1'b0, w_sew});
    assign w_last    = ({1'b0, r_beat} == (w_total - 5'd1));
    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_capture = (r_state == ST_WAIT) && mem_valid;

    v_lsu_addrgen u_addrgen (
        .base      (r_base),
        .stride    (r_stride),
        .op        (r_op),
        .beat      (r_beat),
        .mem_addr0 (w_ga0),
        .mem_addr1 (w_ga1),
        .mem_addr2 (w_ga2),
        .mem_addr3 (w_ga3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        mem_req     = 1'b0;
        l_done      = 1'b0;
        mem_addr0   = 32'd0;
        mem_addr1   = 32'd0;
        mem_addr2   = 32'd0;
        mem_addr3   = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                busy        = 1'b1;
                mem_req     = 1'b1;
                mem_addr0   = w_ga0;
                mem_addr1   = w_ga1;
                mem_addr2   = w_ga2;
                mem_addr3   = w_ga3;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (mem_valid) w_state_nxt = w_last ? ST_DONE : ST_REQ;
            end
            default: begin
                busy        = 1'b1;
                l_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Element i = beat*4 + k lands at bit offset i*SEW; offsets never exceed the image
    always_comb begin
        w_img = r_img;
        w_off = '0;
        for (int k = 0; k < LANES; k++) begin
            w_off = OFF_W'({r_beat, 2'(k)}) << ({1'b0, w_sew} + 3'd3);
            case (w_sew)
                2'd0:    w_img[w_off +: 8]  = w_lane[k][7:0];
                2'd1:    w_img[w_off +: 16] = w_lane[k][15:0];
                default: w_img[w_off +: 32] = w_lane[k];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= 4'd0;
            r_lmul   <= 3'd0;
            r_base   <= 32'd0;
            r_stride <= 32'd0;
            r_beat   <= 4'd0;
            r_img    <= '0;
        end else if (w_accept) begin
            r_op     <= vlsu_op;
            r_lmul   <= lmul;
            r_base   <= base_addr;
            r_stride <= stride;
            r_beat   <= 4'd0;
            r_img    <= '0;
        end else if (w_capture) begin
            r_img    <= w_img;
            r_beat   <= r_beat + 4'd1;
        end
    end

    assign l_data_out = r_img;

endmodule
`default_nettype wire

// File: tb/tb_v_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_load_sequencer
// Brief    : Directed scoreboard bench for the vector load sequencer.
// Revision : 1.0
// ============================================================================
module tb_v_load_sequencer;
    import v_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    vlsu_op;
    logic [2:0]    lmul;
    logic [31:0]   base_addr, stride;
    logic          busy, mem_req, mem_valid, l_done;
    logic [31:0]   mem_addr0, mem_addr1, mem_addr2, mem_addr3;
    logic [31:0]   l_data_in0, l_data_in1, l_data_in2, l_data_in3;
    logic [511:0]  l_data_out;

    int            total = 0;
    int            bad   = 0;
    int            cnt;
    int            nbeats_g;
    logic [31:0]   dbase_g;
    logic [511:0]  held_img;
    logic [31:0]   addr_q [$];
    logic [511:0]  img_q  [$];

    v_load_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vlsu_op    (vlsu_op),
        .lmul       (lmul),
        .base_addr  (base_addr),
        .stride     (stride),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr0  (mem_addr0),
        .mem_addr1  (mem_addr1),
        .mem_addr2  (mem_addr2),
        .mem_addr3  (mem_addr3),
        .mem_valid  (mem_valid),
        .l_data_in0 (l_data_in0),
        .l_data_in1 (l_data_in1),
        .l_data_in2 (l_data_in2),
        .l_data_in3 (l_data_in3),
        .l_data_out (l_data_out),
        .l_done     (l_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Builds the expected addresses and image, then issues start at an IDLE negedge.
    task automatic accept(input logic [3:0] op, input logic [2:0] lm, input logic [31:0] b,
                          input logic [31:0] s, input logic [31:0] d, input bit hold);
        int sewb, nreg, nel;
        bit strided;
        logic [31:0] dv;
        logic [511:0] img;
        strided = (op == VLSU_VLSE8) || (op == VLSU_VLSE16) || (op == VLSU_VLSE32);
        if (op == VLSU_VLE8 || op == VLSU_VLSE8)        sewb = 1;
        else if (op == VLSU_VLE16 || op == VLSU_VLSE16) sewb = 2;
        else                                            sewb = 4;
        nreg = (lm == 3'b001) ? 2 : (lm == 3'b010) ? 4 : 1;
        nel = nreg * 16 / sewb;
        nbeats_g = nel / 4;
        dbase_g = d;
        img = '0;
        for (int i = 0; i < nel; i++) begin
            addr_q.push_back(strided ? b + 32'(i) * s : b + 32'(i * sewb));
            dv = d + 32'(i);
            for (int j = 0; j < sewb * 8; j++) img[i * sewb * 8 + j] = dv[j];
        end
        img_q.push_back(img);
        vlsu_op = op; lmul = lm; base_addr = b; stride = s; start = 1'b1;
        @(negedge clk);
        cnt = 1;
        if (!hold) start = 1'b0;
    endtask

    // Entered at the REQ negedge of beat b; leaves at the negedge after capture.
    task automatic do_beat(input int b, input int dly, input bit spur, input bit cap);
        chk("mem_req", mem_req, 1);
        chk("addr0", mem_addr0, addr_q.pop_front());
        chk("addr1", mem_addr1, addr_q.pop_front());
        chk("addr2", mem_addr2, addr_q.pop_front());
        chk("addr3", mem_addr3, addr_q.pop_front());
        if (spur) begin
            mem_valid = 1'b1;
            l_data_in0 = 32'hDEAD_BEEF; l_data_in1 = 32'hDEAD_BEEF;
            l_data_in2 = 32'hDEAD_BEEF; l_data_in3 = 32'hDEAD_BEEF;
        end
        @(negedge clk); cnt++;
        mem_valid = 1'b0;
        chk("req_drop", mem_req, 0);
        chk("addr_idle", mem_addr0, 0);
        if (cap) begin
            repeat (dly) begin
                @(negedge clk); cnt++;
                chk("wait_hold", {busy, mem_req, l_done}, 3'b100);
            end
            mem_valid  = 1'b1;
            l_data_in0 = dbase_g + 32'(b * 4 + 0);
            l_data_in1 = dbase_g + 32'(b * 4 + 1);
            l_data_in2 = dbase_g + 32'(b * 4 + 2);
            l_data_in3 = dbase_g + 32'(b * 4 + 3);
            @(negedge clk); cnt++;
            mem_valid = 1'b0;
        end
    endtask

    task automatic run_beats(input int dly0, input bit spur0);
        for (int bt = 0; bt < nbeats_g; bt++)
            do_beat(bt, (bt == 0) ? dly0 : 0, (bt == 0) ? spur0 : 1'b0, 1'b1);
    endtask

    task automatic finish_cmd(input int extra);
        chk("l_done", l_done, 1);
        chk("busy_done", busy, 1);
        chk("latency", cnt, 2 * nbeats_g + 1 + extra);
        held_img = img_q.pop_front();
        chk("image", l_data_out, held_img);
        @(negedge clk);
        chk("done_pulse", l_done, 0);
        chk("busy_fall", busy, 0);
        chk("image_held", l_data_out, held_img);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vlsu_op = 4'd0; lmul = 3'd0; base_addr = 32'd0;
        stride = 32'd0; mem_valid = 1'b0;
        l_data_in0 = 32'd0; l_data_in1 = 32'd0; l_data_in2 = 32'd0; l_data_in3 = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {busy, mem_req, l_done}, 3'b000);
        chk("rst_addr", {mem_addr0, mem_addr1, mem_addr2, mem_addr3}, 0);
        chk("rst_img", l_data_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // VLE32 single register
        accept(VLSU_VLE32, 3'b000, 32'h0000_1000, 32'd0, 32'h0000_00A0, 1'b0);
        run_beats(0, 1'b0);
        finish_cmd(0);

        // VLE8 four-register group, byte i = i
        accept(VLSU_VLE8, 3'b010, 32'h0, 32'd0, 32'h0000_0100, 1'b0);
        run_beats(0, 1'b0);
        finish_cmd(0);

        // VLSE16 two-register group with address wrap
        accept(VLSU_VLSE16, 3'b001, 32'hFFFF_FFF0, 32'd8, 32'h5A5A_C000, 1'b0);
        run_beats(0, 1'b0);
        finish_cmd(0);

        // Slow memory on beat 0 plus a spurious valid during REQ
        accept(VLSU_VLE16, 3'b000, 32'h0000_4000, 32'd0, 32'h7700_1100, 1'b0);
        run_beats(4, 1'b1);
        finish_cmd(4);

        // Asynchronous reset in WAIT of beat 1
        accept(VLSU_VLE16, 3'b010, 32'h0000_8000, 32'd0, 32'h0000_3300, 1'b0);
        do_beat(0, 0, 1'b0, 1'b1);
        do_beat(1, 0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_ctl", {busy, mem_req, l_done}, 3'b000);
        chk("arst_addr", mem_addr0, 0);
        chk("arst_img", l_data_out, 0);
        #1;
        rst = 1'b0;
        addr_q.delete();
        img_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("arst_quiet", {busy, l_done}, 2'b00);
        end
        accept(VLSU_VLE32, 3'b000, 32'h0000_0200, 32'd0, 32'h1234_5670, 1'b0);
        run_beats(0, 1'b0);
        finish_cmd(0);

        // start held high, unknown op behaves as VLE32 (stride ignored)
        accept(4'hF, 3'b001, 32'h0000_2000, 32'h0000_0100, 32'hCAFE_0000, 1'b1);
        run_beats(0, 1'b0);
        finish_cmd(0);
        accept(4'hF, 3'b001, 32'h0000_2000, 32'h0000_0100, 32'hCAFE_0000, 1'b0);
        run_beats(0, 1'b0);
        finish_cmd(0);
        @(negedge clk);
        chk("no_reaccept", {busy, mem_req}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
